fpmul_issue_ctrl: RTL and testbench

- Issue/retire controller for the 3-stage FP32 multiplier pipeline (stage 1 through the normalise stage).
- The multiplier stages have no stall input. This block therefore admits a new operation only when a result-buffer slot is guaranteed free.
- It tracks in-flight operations with a valid/tag shift register and captures each pipeline result into a result FIFO.
- It presents results to the FPU writeback through a valid/ready handshake.

---
 rtl/fpmul_ctrl_pkg.sv | 25 ++
 rtl/fpmul_res_fifo.sv | 75 +++++++
 rtl/fpmul_issue_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fpmul_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_ctrl_pkg.sv
// fpmul_ctrl_pkg
//   Shared definitions for the FP32 multiplier issue/retire controller:
//   field widths of the stage-3 result, default pipeline latency, result
//   buffer depth and tag width, and the default result record layout.
//   No ports (package).

package fpmul_ctrl_pkg;

    localparam int unsigned EXP_W     = 9;
    localparam int unsigned FRAC_W    = 23;
    localparam int unsigned DEF_LAT   = 3;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_TAG_W = 5;

    // Result record as buffered between the multiplier and writeback.
    // The controller re-declares it with its own TAG_W; this one is the
    // default element type of the result FIFO.
    typedef struct packed {
        logic                 sign;
        logic [EXP_W-1:0]     exp;
        logic [FRAC_W-1:0]    frac;
        logic [DEF_TAG_W-1:0] tag;
    } res_rec_t;

endpackage

// File: rtl/fpmul_res_fifo.sv
// fpmul_res_fifo
//   DEPTH-entry synchronous result FIFO. Registered read side: a pushed
//   entry becomes visible at rd_data the cycle after the push edge.
//   Ports:
//     clk, rst      clock, asynchronous active-low reset (pointers/count)
//     push, wr_data write strobe and record
//     pop           read strobe (head advances on the edge)
//     clear         synchronous clear of pointers and count, wins over push/pop
//     rd_data       head record (valid when !empty)
//     full, empty   occupancy flags
//     count         number of stored entries

import fpmul_ctrl_pkg::*;

module fpmul_res_fifo #(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter type         rec_t = res_rec_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  rec_t                         wr_data,
    input  logic                         pop,
    input  logic                         clear,
    output rec_t                         rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fpmul_issue_ctrl.sv
// fpmul_issue_ctrl
//   Issue/retire controller for the 3-stage FP32 multiplier. The multiplier
//   cannot stall, so an operation is admitted only while a credit (result
//   buffer slot) is free. In-flight operations are tracked by a valid/tag
//   shift register; stage-3 results are captured into a result FIFO and
//   handed to writeback through a valid/ready handshake.
//   Ports:
//     clk, rst                  clock, asynchronous active-low reset
//     in_valid/in_ready/in_tag  operation request handshake and its tag
//     flush                     kill all in-flight and buffered operations
//     pipe_issue                stage-1 operand capture strobe
//     pipe_sign/exp/mant        stage-3 result fields
//     out_valid/out_ready       result handshake to writeback
//     out_sign/exp/mant/tag     result record (0 while no result is held)
//     busy                      credits outstanding
//   Optional build macro FPMUL_PERF_CNT_EN adds perf_issued / perf_stall.

import fpmul_ctrl_pkg::*;

module fpmul_issue_ctrl #(
    parameter int unsigned LAT   = DEF_LAT,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              pipe_issue,
    input  logic              pipe_sign,
    input  logic [EXP_W-1:0]  pipe_exp,
    input  logic [FRAC_W-1:0] pipe_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_mant,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
`ifdef FPMUL_PERF_CNT_EN
   ,output logic [31:0]       perf_issued
   ,output logic [31:0]       perf_stall
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic [TAG_W-1:0]  tag;
    } rec_t;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [LAT-1:0]   vld;
    logic [TAG_W-1:0] tag_sr [LAT];

    logic             issue;
    logic             pop;
    logic             push;
    rec_t             push_rec;
    rec_t             head;
    rec_t             shown;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // ---------------------------------------------------------------
    // Credits: one per operation from issue until its result is popped,
    // so FIFO occupancy plus in-flight operations never exceeds DEPTH.
    // ---------------------------------------------------------------
    assign in_ready   = (cnt < CNT_W'(DEPTH)) & ~flush;
    assign issue      = in_valid & in_ready;
    assign pipe_issue = issue;
    assign busy       = (cnt != '0);

    always_comb begin
        cnt_nxt = cnt;
        if (issue && !pop)
            cnt_nxt = cnt + CNT_W'(1);
        else if (pop && !issue)
            cnt_nxt = cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (flush)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

    // ---------------------------------------------------------------
    // In-flight tracking: vld[LAT-1] marks the cycle the issued operation
    // is at the stage-3 output. Tags shift unconditionally; only vld needs
    // clearing on flush.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else begin
            vld[0] <= issue;
            for (int unsigned i = 1; i < LAT; i++)
                vld[i] <= vld[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_sr <= '{default: '0};
        end else begin
            if (issue) tag_sr[0] <= in_tag;
            for (int unsigned i = 1; i < LAT; i++)
                tag_sr[i] <= tag_sr[i-1];
        end
    end

    // ---------------------------------------------------------------
    // Result capture and writeback handshake. During flush the FIFO clear
    // overrides any capture, and the output is hidden so nothing pops.
    // ---------------------------------------------------------------
    assign push     = vld[LAT-1];
    assign push_rec = '{sign: pipe_sign, exp: pipe_exp, frac: pipe_mant,
                        tag: tag_sr[LAT-1]};

    fpmul_res_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (push_rec),
        .pop     (pop),
        .clear   (flush),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid = ~fifo_empty & ~flush;
    assign pop       = out_valid & out_ready;
    assign shown     = fifo_empty ? '0 : head;
    assign out_sign  = shown.sign;
    assign out_exp   = shown.exp;
    assign out_mant  = shown.frac;
    assign out_tag   = shown.tag;

    // The credit bound makes a capture into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_full));
    a_occ_le_cnt: assert property (@(posedge clk) disable iff (!rst)
        fifo_count <= cnt);

`ifdef FPMUL_PERF_CNT_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (issue)
                perf_issued <= perf_issued + 32'd1;
            if (in_valid && !in_ready && !flush)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_fpmul_issue_ctrl.sv
module tb_fpmul_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_tag;
    logic        flush;
    logic        pipe_issue;
    logic        pipe_sign;
    logic [8:0]  pipe_exp;
    logic [22:0] pipe_mant;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [8:0]  out_exp;
    logic [22:0] out_mant;
    logic [4:0]  out_tag;
    logic        busy;
`ifdef FPMUL_PERF_CNT_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    fpmul_issue_ctrl #(.LAT(3), .DEPTH(4), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tag     (in_tag),
        .flush      (flush),
        .pipe_issue (pipe_issue),
        .pipe_sign  (pipe_sign),
        .pipe_exp   (pipe_exp),
        .pipe_mant  (pipe_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_mant   (out_mant),
        .out_tag    (out_tag),
        .busy       (busy)
`ifdef FPMUL_PERF_CNT_EN
       ,.perf_issued(perf_issued)
       ,.perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // New cycle: inputs are driven 1 time unit after the rising edge,
    // outputs are sampled 1 unit later, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pipe(input logic s, input logic [8:0] e, input logic [22:0] m);
        pipe_sign = s;
        pipe_exp  = e;
        pipe_mant = m;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nxt;
        int k;
        int o_cyc [8];
        logic [8:0] ev;

        o_cyc = '{4, 5, 6, 7, 9, 10, 11, 12};

        // ---------------- reset state ----------------
        rst = 1'b0; in_valid = 1'b0; in_tag = '0; flush = 1'b0;
        out_ready = 1'b0; pipe(1'b0, '0, '0);
        #2;
        chk("rst_in_ready",   in_ready,   1);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_busy",       busy,       0);
        chk("rst_pipe_issue", pipe_issue, 0);
        chk("rst_out_tag",    out_tag,    0);
        chk("rst_out_exp",    out_exp,    0);
        tick();
        rst = 1'b1;

        // ---------------- single op ----------------
        in_valid = 1'b1; in_tag = 5'd5;                 // cycle 0
        settle();
        chk("single_issue", pipe_issue, 1);
        tick(); in_valid = 1'b0; settle();              // cycle 1
        chk("single_busy_c1",  busy,      1);
        chk("single_valid_c1", out_valid, 0);
        tick();                                         // cycle 2
        tick(); pipe(1'b0, 9'h080, 23'h200000); settle(); // cycle 3
        chk("single_valid_c3", out_valid, 0);
        tick(); pipe(1'b1, 9'h1ff, 23'h7fffff); settle(); // cycle 4
        chk("single_valid_c4", out_valid, 1);
        chk("single_tag_c4",   out_tag,   5);
        chk("single_sign_c4",  out_sign,  0);
        chk("single_exp_c4",   out_exp,   9'h080);
        chk("single_mant_c4",  out_mant,  23'h200000);
        tick(); out_ready = 1'b1; settle();             // cycle 5: held, then popped
        chk("single_hold_valid", out_valid, 1);
        chk("single_hold_tag",   out_tag,   5);
        chk("single_hold_mant",  out_mant,  23'h200000);
        chk("single_busy_c5",    busy,      1);
        tick(); out_ready = 1'b0; settle();             // cycle 6
        chk("single_valid_c6", out_valid, 0);
        chk("single_busy_c6",  busy,      0);

        // ---------------- streaming, tags 0..7 ----------------
        // The requester holds each tag until accepted. Credits run out in
        // cycle 4 (four issued, first pop not yet applied), so tags 4..7
        // issue in cycles 5..8 and results land in cycles 4-7 and 9-12.
        out_ready = 1'b1;
        nxt = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            pipe(c[0], 9'(9'h040 + c), 23'(c));
            in_valid = (nxt < 8);
            in_tag   = 5'(nxt);
            settle();
            if (c <= 8)
                chk($sformatf("stream_in_ready_c%0d", c), in_ready, (c == 4) ? 0 : 1);
            k = -1;
            for (int j = 0; j < 8; j++)
                if (o_cyc[j] == c) k = j;
            if (k >= 0) begin
                // Captured one cycle before it shows: cycle c-1.
                ev = 9'(9'h040 + c - 1);
                chk($sformatf("stream_valid_c%0d", c), out_valid, 1);
                chk($sformatf("stream_tag_c%0d", c),   out_tag,   k);
                chk($sformatf("stream_exp_c%0d", c),   out_exp,   ev);
                chk($sformatf("stream_sign_c%0d", c),  out_sign,  (c - 1) % 2);
            end else begin
                chk($sformatf("stream_idle_c%0d", c), out_valid, 0);
            end
            if (c == 13) chk("stream_busy_end", busy, 0);
            if (pipe_issue) nxt++;
        end
        in_valid = 1'b0;

        // ---------------- backpressure + simultaneous issue/pop ----------------
        out_ready = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            pipe(1'b0, 9'(9'h080 + c), 23'(c + 100));
            in_valid  = (c < 6) || (c == 8) || (c == 9);
            in_tag    = (c < 6) ? 5'(10 + c) : 5'd20;
            out_ready = (c >= 8);
            settle();
            if (c < 6)
                chk($sformatf("bp_in_ready_c%0d", c), in_ready, (c < 4) ? 1 : 0);
            case (c)
                7: begin
                    chk("bp_valid_c7", out_valid, 1);
                    chk("bp_tag_c7",   out_tag,   10);
                end
                8: begin
                    chk("bp_in_ready_c8", in_ready,   0);
                    chk("bp_issue_c8",    pipe_issue, 0);
                    chk("bp_valid_c8",    out_valid,  1);
                    chk("bp_tag_c8",      out_tag,    10);
                    chk("bp_exp_c8",      out_exp,    9'h083);
                end
                9: begin
                    chk("bp_in_ready_c9", in_ready,   1);
                    chk("bp_issue_c9",    pipe_issue, 1);
                    chk("bp_tag_c9",      out_tag,    11);
                    chk("bp_exp_c9",      out_exp,    9'h084);
                end
                10: chk("bp_tag_c10", out_tag, 12);
                11: begin
                    chk("bp_tag_c11",  out_tag,  13);
                    chk("bp_mant_c11", out_mant, 23'd106);
                end
                12: begin
                    chk("bp_valid_c12", out_valid, 0);
                    chk("bp_busy_c12",  busy,      1);
                end
                13: begin
                    chk("bp_valid_c13", out_valid, 1);
                    chk("bp_tag_c13",   out_tag,   20);
                    chk("bp_exp_c13",   out_exp,   9'h08c);
                end
                14: begin
                    chk("bp_valid_c14", out_valid, 0);
                    chk("bp_busy_c14",  busy,      0);
                end
                default: ;
            endcase
        end
        in_valid = 1'b0;

        // ---------------- flush ----------------
        out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            tick();
            pipe(1'b1, 9'h1ff, 23'h7fffff);
            in_valid = (c < 3);
            in_tag   = 5'(c + 1);
            flush    = (c == 2);
            settle();
            if (c == 2) begin
                chk("flush_in_ready_c2", in_ready,   0);
                chk("flush_issue_c2",    pipe_issue, 0);
                chk("flush_busy_c2",     busy,       1);
            end
            if (c == 3) begin
                chk("flush_in_ready_c3", in_ready, 1);
                chk("flush_busy_c3",     busy,     0);
            end
            chk($sformatf("flush_valid_c%0d", c), out_valid, 0);
        end
        flush = 1'b0;
        in_valid = 1'b0;

        // ---------------- asynchronous reset mid-stream ----------------
        out_ready = 1'b0;
        tick(); in_valid = 1'b1; in_tag = 5'd7;         // cycle 0
        tick(); in_tag = 5'd8;                          // cycle 1
        tick(); in_valid = 1'b0;                        // cycle 2
        tick(); pipe(1'b0, 9'h055, 23'd5);              // cycle 3
        tick(); settle();                               // cycle 4
        chk("areset_pre_valid", out_valid, 1);
        chk("areset_pre_tag",   out_tag,   7);
        #2 rst = 1'b0;                                  // between edges
        #1;
        chk("areset_valid", out_valid, 0);
        chk("areset_busy",  busy,      0);
        chk("areset_ready", in_ready,  1);
        tick();
        rst = 1'b1;
        in_valid = 1'b1; in_tag = 5'd9;                 // cycle 0'
        settle();
        chk("areset_issue", pipe_issue, 1);
        tick(); in_valid = 1'b0;                        // cycle 1'
        tick();                                         // cycle 2'
        tick(); pipe(1'b1, 9'h1aa, 23'h012345); settle(); // cycle 3'
        chk("areset_valid_c3", out_valid, 0);
        tick(); pipe(1'b0, 9'h000, 23'h000000); out_ready = 1'b1; settle(); // cycle 4'
        chk("areset_valid_c4", out_valid, 1);
        chk("areset_tag_c4",   out_tag,   9);
        chk("areset_sign_c4",  out_sign,  1);
        chk("areset_exp_c4",   out_exp,   9'h1aa);
        chk("areset_mant_c4",  out_mant,  23'h012345);
        tick(); settle();                               // cycle 5'
        chk("areset_busy_c5",  busy,      0);
        chk("areset_valid_c5", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
